sub_bytes_engine: RTL and testbench

- Multi-cycle AES SubBytes / InvSubBytes engine for one 128-bit state.
- Accepts a block over a valid/ready handshake, latches the direction, and substitutes `LANES` bytes per clock.
- Substitution uses a shared GF(2^8) multiplicative-inverse datapath with forward/inverse affine transforms.
- Sits between the round-key adder and ShiftRows/InvShiftRows in the round datapath. It replaces the per-byte lookup tables with one area-scalable unit.

---
 rtl/sub_bytes_engine.sv | 161 ++++++++++++++++
 tb/tb_sub_bytes_engine.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_engine.sv
// Multi-cycle AES SubBytes/InvSubBytes engine: LANES bytes per clock through a shared GF(2^8) inverter.
// Define SUB_BYTES_INVERSE_EN to honour `inverse`; undefined builds are forward-only.
module sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         inverse,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  localparam int N = 16 / LANES;
  localparam logic [3:0] LAST_BEAT = 4'(N - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} fsm_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128, which also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(x, x);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

`ifdef SUB_BYTES_INVERSE_EN
  function automatic logic [7:0] affine_inv(input logic [7:0] b);
    return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
  endfunction

  // The inverter sits between the two affine stages so both directions share it.
  function automatic logic [7:0] sub_byte(input logic [7:0] x, input logic mode);
    logic [7:0] t;
    t = gf_inv(mode ? affine_inv(x) : x);
    return mode ? t : affine_fwd(t);
  endfunction
`else
  function automatic logic [7:0] sub_byte(input logic [7:0] x);
    return affine_fwd(gf_inv(x));
  endfunction
`endif

  fsm_t              r_fsm;
  logic [15:0][7:0]  r_state;
  logic [3:0]        r_beat;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;
  logic [15:0][7:0]  w_next_state;
  logic [7:0]        w_lane_in  [LANES];
  logic [7:0]        w_lane_out [LANES];

`ifdef SUB_BYTES_INVERSE_EN
  logic r_mode;
`else
  logic w_unused_inverse;
  assign w_unused_inverse = inverse;
`endif

  // Byte k of the block lives in r_state[15-k].
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lane_in[g] = r_state[4'(15 - (int'(r_beat) * LANES + g))];
`ifdef SUB_BYTES_INVERSE_EN
    assign w_lane_out[g] = sub_byte(w_lane_in[g], r_mode);
`else
    assign w_lane_out[g] = sub_byte(w_lane_in[g]);
`endif
  end

  always_comb begin
    // NOTE: full default before the loop so no bit of w_next_state can infer a latch.
    w_next_state = r_state;
    for (int l = 0; l < LANES; l++) begin
      w_next_state[4'(15 - (int'(r_beat) * LANES + l))] = w_lane_out[l];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking throughout so every register samples pre-edge values.
    if (reset) begin
      r_fsm       <= S_IDLE;
      r_state     <= '0;
      r_beat      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
`ifdef SUB_BYTES_INVERSE_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (in_valid) begin
            r_state    <= data_in;
            r_beat     <= '0;
`ifdef SUB_BYTES_INVERSE_EN
            r_mode     <= inverse;
`endif
            r_fsm      <= S_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_RUN: begin
          r_state <= w_next_state;
          if (r_beat == LAST_BEAT) begin
            r_fsm       <= S_HOLD;
            r_out_valid <= 1'b1;
          end else begin
            r_beat <= r_beat + 4'd1;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_fsm       <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: r_fsm <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign data_out  = r_state;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Directed bench for sub_bytes_engine: four instances (LANES 4, 1, 16, 2) checked against the FIPS-197 table.
module tb_sub_bytes_engine;

`ifdef SUB_BYTES_INVERSE_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic [127:0] data_in   [4];
  logic         inverse   [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] data_out  [4];
  logic         busy      [4];

  int tests = 0;
  int fails = 0;

  logic [2047:0] sbox_bits;
  logic [7:0]    sbox  [256];
  logic [7:0]    isbox [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : 2;
    sub_bytes_engine #(.LANES(L)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .data_in   (data_in[g]),
      .inverse   (inverse[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .data_out  (data_out[g]),
      .busy      (busy[g])
    );
  end

  task automatic init_tables();
    sbox_bits = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
                 128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
                 128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
                 128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
                 128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
                 128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
                 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
                 128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox[i] = sbox_bits[2047 - 8*i -: 8];
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
  endtask

  function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = d[127 - 8*i -: 8];
      r[127 - 8*i -: 8] = (INV_EN && inv) ? isbox[b] : sbox[b];
    end
    return r;
  endfunction

  // Waits (bounded) for out_valid; lat counts negedges since the negedge that followed the last call site edge.
  task automatic wait_out(input int idx, output int lat);
    lat = 0;
    while (out_valid[idx] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_block(input int idx, input logic [127:0] din, input logic inv,
                           input logic [127:0] exp, input int n, input string name);
    int lat;
    @(negedge clk);
    tests++;
    if (in_ready[idx] !== 1'b1) begin
      fails++; $display("FAIL %s in_ready before accept: got %b want 1", name, in_ready[idx]);
    end
    in_valid[idx] = 1'b1; data_in[idx] = din; inverse[idx] = inv; out_ready[idx] = 1'b0;
    @(negedge clk);
    in_valid[idx] = 1'b0; inverse[idx] = ~inv; data_in[idx] = '0;
    wait_out(idx, lat);
    tests++;
    if (lat !== n) begin fails++; $display("FAIL %s latency: got %0d want %0d", name, lat, n); end
    tests++;
    if (data_out[idx] !== exp) begin
      fails++; $display("FAIL %s data_out: got %h want %h", name, data_out[idx], exp);
    end
    tests++;
    if (in_ready[idx] !== 1'b0 || busy[idx] !== 1'b1) begin
      fails++; $display("FAIL %s hold flags: in_ready %b busy %b want 0 1", name, in_ready[idx], busy[idx]);
    end
    out_ready[idx] = 1'b1;
    @(negedge clk);
    out_ready[idx] = 1'b0;
    tests++;
    if (out_valid[idx] !== 1'b0 || in_ready[idx] !== 1'b1 || busy[idx] !== 1'b0) begin
      fails++; $display("FAIL %s after handshake: out_valid %b in_ready %b busy %b want 0 1 0",
                        name, out_valid[idx], in_ready[idx], busy[idx]);
    end
  endtask

  task automatic check_reset_values(input int idx, input string name);
    tests++;
    if (in_ready[idx] !== 1'b1 || out_valid[idx] !== 1'b0 || busy[idx] !== 1'b0 || data_out[idx] !== '0) begin
      fails++; $display("FAIL %s dut%0d: in_ready %b out_valid %b busy %b data_out %h want 1 0 0 0",
                        name, idx, in_ready[idx], out_valid[idx], busy[idx], data_out[idx]);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) check_reset_values(i, "reset");
    reset = 1'b0;
  endtask

  task automatic test_forward_lanes4();
    run_block(0, 128'h00112233445566778899aabbccddeeff, 1'b0,
              128'h638293c31bfc33f5c4eeacea4bc12816, 4, "fwd_l4");
  endtask

  task automatic test_inverse_lanes1();
    logic [127:0] din;
    din = 128'h638293c31bfc33f5c4eeacea4bc12816;
    run_block(1, din, 1'b1, INV_EN ? 128'h00112233445566778899aabbccddeeff : model(din, 1'b0),
              16, "inv_l1");
  endtask

  task automatic test_exhaustive_lanes16();
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 256; v++) begin
        logic [7:0] e;
        e = (INV_EN && m == 1) ? isbox[v] : sbox[v];
        run_block(2, {16{8'(v)}}, m[0], {16{e}}, 1, m == 0 ? "exh_fwd" : "exh_inv");
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, b;
    int lat;
    a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    b = 128'hffeeddccbbaa99887766554433221100;
    @(negedge clk);
    in_valid[0] = 1'b1; data_in[0] = a; inverse[0] = 1'b0; out_ready[0] = 1'b0;
    @(negedge clk);
    data_in[0] = b;
    wait_out(0, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL bp latency A: got %0d want 4", lat); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (data_out[0] !== model(a, 1'b0) || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) begin
        fails++; $display("FAIL bp stall cycle %0d: data_out %h out_valid %b in_ready %b want %h 1 0",
                          c, data_out[0], out_valid[0], in_ready[0], model(a, 1'b0));
      end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    tests++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      fails++; $display("FAIL bp release: out_valid %b in_ready %b want 0 1", out_valid[0], in_ready[0]);
    end
    @(negedge clk);
    in_valid[0] = 1'b0;
    tests++;
    if (in_ready[0] !== 1'b0 || busy[0] !== 1'b1) begin
      fails++; $display("FAIL bp accept B: in_ready %b busy %b want 0 1", in_ready[0], busy[0]);
    end
    wait_out(0, lat);
    tests++;
    if (lat !== 4 || data_out[0] !== model(b, 1'b0)) begin
      fails++; $display("FAIL bp block B: lat %0d data_out %h want 4 %h", lat, data_out[0], model(b, 1'b0));
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [127:0] a, b;
    int lat;
    a = 128'h3243f6a8885a308d313198a2e0370734;
    b = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    @(negedge clk);
    in_valid[0] = 1'b1; data_in[0] = a; inverse[0] = 1'b0; out_ready[0] = 1'b1;
    @(negedge clk);
    data_in[0] = b;
    for (int k = 0; k <= 6; k++) begin
      tests++;
      if (in_ready[0] !== (k == 5) || out_valid[0] !== (k == 4)) begin
        fails++; $display("FAIL b2b edge %0d: in_ready %b out_valid %b want %b %b",
                          k, in_ready[0], out_valid[0], k == 5, k == 4);
      end
      if (k == 4) begin
        tests++;
        if (data_out[0] !== model(a, 1'b0)) begin
          fails++; $display("FAIL b2b block A: got %h want %h", data_out[0], model(a, 1'b0));
        end
      end
      if (k == 6) begin
        in_valid[0] = 1'b0; out_ready[0] = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
    wait_out(0, lat);
    tests++;
    if (lat !== 4 || data_out[0] !== model(b, 1'b0)) begin
      fails++; $display("FAIL b2b block B: lat %0d data_out %h want 4 %h", lat, data_out[0], model(b, 1'b0));
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] a, b;
    a = 128'hdeadbeefcafef00d0123456789abcdef;
    b = 128'h00000000000000000000000000000001;
    @(negedge clk);
    in_valid[3] = 1'b1; data_in[3] = a; inverse[3] = 1'b0;
    @(negedge clk);
    in_valid[3] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_reset_values(3, "mid_run_reset");
    repeat (2) @(negedge clk);
    check_reset_values(3, "reset_held");
    reset = 1'b0;
    run_block(3, b, 1'b0, model(b, 1'b0), 8, "after_reset");
  endtask

  task automatic test_zero_inverse();
    run_block(2, '0, 1'b1, INV_EN ? {16{8'h52}} : {16{8'h63}}, 1, "zero_inv");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      in_valid[i] = 1'b0; data_in[i] = '0; inverse[i] = 1'b0; out_ready[i] = 1'b0;
    end
    init_tables();
    test_reset();
    test_forward_lanes4();
    test_inverse_lanes1();
    test_exhaustive_lanes16();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    test_zero_inverse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
